// File: rtl/scope_scan_seq.sv
// Oscilloscope XY scan sequencer: one point per clk_scan rising edge, in the order
// ball, left paddle, right paddle. Game coordinates are captured once per frame.
module scope_scan_seq #(
    parameter int DW       = 8,
    parameter int PAD_PTS  = 16,
    parameter int PAD_STEP = 2,
    parameter int LEFT_X   = 8,
    parameter int RIGHT_X  = 247
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          clk_scan,
    input  logic          enable,
    input  logic [DW-1:0] ball_x,
    input  logic [DW-1:0] ball_y,
    input  logic [DW-1:0] pad_l_y,
    input  logic [DW-1:0] pad_r_y,
    output logic [DW-1:0] dac_x,
    output logic [DW-1:0] dac_y,
    output logic          point_valid,
    output logic          frame_start
);

    localparam logic [1:0] ST_BALL = 2'd0;
    localparam logic [1:0] ST_LPAD = 2'd1;
    localparam logic [1:0] ST_RPAD = 2'd2;
    localparam int         SW      = DW + 7;

    // Paddle point Y, saturated so a paddle near the top never wraps to the bottom.
    function automatic logic [DW-1:0] pad_point(input logic [DW-1:0] base,
                                                input logic [5:0]    idx);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(idx) * SW'(PAD_STEP);
        if (|sum[SW-1:DW]) return '1;
        return sum[DW-1:0];
    endfunction

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s3_q, s3_d;
    logic [1:0]    state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [DW-1:0] sl_y_q, sl_y_d;
    logic [DW-1:0] sr_y_q, sr_y_d;
    logic [DW-1:0] dac_x_q, dac_x_d;
    logic [DW-1:0] dac_y_q, dac_y_d;
    logic          point_valid_q, point_valid_d;
    logic          frame_start_q, frame_start_d;

    logic tick;
    logic accept;
    logic idx_last;

    assign tick     = s2_q & ~s3_q;
    assign accept   = tick & enable;
    assign idx_last = (idx_q == 6'(PAD_PTS - 1));

    always_comb begin
        // NOTE: every _d starts from a default so no path through this block infers a latch.
        s1_d          = clk_scan;
        s2_d          = s1_q;
        s3_d          = s2_q;
        state_d       = state_q;
        idx_d         = idx_q;
        sl_y_d        = sl_y_q;
        sr_y_d        = sr_y_q;
        dac_x_d       = dac_x_q;
        dac_y_d       = dac_y_q;
        point_valid_d = 1'b0;
        frame_start_d = 1'b0;

        if (accept) begin
            point_valid_d = 1'b1;
            case (state_q)
                ST_BALL: begin
                    // Ball point leaves in the capture cycle, so only paddle Y needs a shadow.
                    sl_y_d        = pad_l_y;
                    sr_y_d        = pad_r_y;
                    dac_x_d       = ball_x;
                    dac_y_d       = ball_y;
                    frame_start_d = 1'b1;
                    idx_d         = '0;
                    state_d       = ST_LPAD;
                end
                ST_LPAD: begin
                    dac_x_d = DW'(LEFT_X);
                    dac_y_d = pad_point(sl_y_q, idx_q);
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_RPAD;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                ST_RPAD: begin
                    dac_x_d = DW'(RIGHT_X);
                    dac_y_d = pad_point(sr_y_q, idx_q);
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_BALL;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                default: begin
                    point_valid_d = 1'b0;
                    idx_d         = '0;
                    state_d       = ST_BALL;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            state_q       <= ST_BALL;
            idx_q         <= '0;
            sl_y_q        <= '0;
            sr_y_q        <= '0;
            dac_x_q       <= '0;
            dac_y_q       <= '0;
            point_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            sl_y_q        <= sl_y_d;
            sr_y_q        <= sr_y_d;
            dac_x_q       <= dac_x_d;
            dac_y_q       <= dac_y_d;
            point_valid_q <= point_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dac_x       = dac_x_q;
    assign dac_y       = dac_y_q;
    assign point_valid = point_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scope_scan_seq.sv
// Self-checking bench for scope_scan_seq: frame-position model with a timed queue of
// expected points, directed scenarios with literal pins, then randomized traffic.
module tb_scope_scan_seq;

    localparam int DW       = 8;
    localparam int PAD_PTS  = 16;
    localparam int PAD_STEP = 2;
    localparam int LEFT_X   = 8;
    localparam int RIGHT_X  = 247;
    localparam int HALF     = 8;
    localparam int FRAME    = 1 + 2 * PAD_PTS;

    logic          sysclk   = 1'b0;
    logic          rst      = 1'b1;
    logic          clk_scan = 1'b0;
    logic          enable   = 1'b0;
    logic [DW-1:0] ball_x   = '0;
    logic [DW-1:0] ball_y   = '0;
    logic [DW-1:0] pad_l_y  = '0;
    logic [DW-1:0] pad_r_y  = '0;
    logic [DW-1:0] dac_x;
    logic [DW-1:0] dac_y;
    logic          point_valid;
    logic          frame_start;

    scope_scan_seq #(
        .DW(DW), .PAD_PTS(PAD_PTS), .PAD_STEP(PAD_STEP), .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X)
    ) dut (
        .sysclk(sysclk), .rst(rst), .clk_scan(clk_scan), .enable(enable),
        .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .dac_x(dac_x), .dac_y(dac_y), .point_valid(point_valid), .frame_start(frame_start)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int            due;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          fs;
    } pt_t;

    pt_t           exp_q[$];
    int            cyc      = 0;
    int            checks   = 0;
    int            failures = 0;
    int            pos      = 0;
    logic [DW-1:0] fl_y     = '0;
    logic [DW-1:0] fr_y     = '0;
    logic [DW-1:0] cur_x    = '0;
    logic [DW-1:0] cur_y    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pad_y(input logic [DW-1:0] base, input int i);
        int s;
        s = int'(base) + i * PAD_STEP;
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    // Expected point for the current frame position; frame inputs are captured at position 0.
    task automatic model_emit();
        pt_t p;
        p.due = cyc + 3;
        p.fs  = 1'b0;
        if (pos == 0) begin
            fl_y = pad_l_y;
            fr_y = pad_r_y;
            p.x  = ball_x;
            p.y  = ball_y;
            p.fs = 1'b1;
        end else if (pos <= PAD_PTS) begin
            p.x = 8'(LEFT_X);
            p.y = pad_y(fl_y, pos - 1);
        end else begin
            p.x = 8'(RIGHT_X);
            p.y = pad_y(fr_y, pos - 1 - PAD_PTS);
        end
        exp_q.push_back(p);
        pos = (pos + 1) % FRAME;
    endtask

    always begin : compare
        pt_t p;
        @(posedge sysclk);
        cyc++;
        #2;
        if (rst) begin
            check("rst_point_valid", point_valid, 0);
            check("rst_frame_start", frame_start, 0);
            check("rst_dac_x", dac_x, 0);
            check("rst_dac_y", dac_y, 0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            p = exp_q.pop_front();
            check("point_valid", point_valid, 1);
            check("frame_start", frame_start, p.fs);
            check("dac_x", dac_x, p.x);
            check("dac_y", dac_y, p.y);
            cur_x = p.x;
            cur_y = p.y;
        end else begin
            check("idle_point_valid", point_valid, 0);
            check("idle_frame_start", frame_start, 0);
            check("hold_dac_x", dac_x, cur_x);
            check("hold_dac_y", dac_y, cur_y);
        end
    end

    // One clk_scan period, starting with the rising edge; ends on a negedge with clk_scan low.
    task automatic tick_period();
        @(negedge sysclk);
        clk_scan = 1'b1;
        if (!rst && enable) model_emit();
        repeat (HALF - 1) @(negedge sysclk);
        clk_scan = 1'b0;
        repeat (HALF) @(negedge sysclk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick_period();
    endtask

    task automatic do_reset(input int toggles);
        @(negedge sysclk);
        rst = 1'b1;
        exp_q.delete();
        pos   = 0;
        cur_x = '0;
        cur_y = '0;
        #1;
        check("async_clr_dac_x", dac_x, 0);
        check("async_clr_dac_y", dac_y, 0);
        check("async_clr_valid", point_valid, 0);
        for (int i = 0; i < toggles; i++) begin
            @(negedge sysclk);
            clk_scan = ~clk_scan;
            @(negedge sysclk);
        end
        clk_scan = 1'b0;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic pin(input string name, input logic [DW-1:0] ex, input logic [DW-1:0] ey);
        check({name, "_x"}, dac_x, ex);
        check({name, "_y"}, dac_y, ey);
    endtask

    initial begin
        // Reset with clk_scan toggling, then first point three edges after the first rise.
        do_reset(6);
        ball_x  = 8'd100;
        ball_y  = 8'd50;
        pad_l_y = 8'd20;
        pad_r_y = 8'd200;
        enable  = 1'b1;
        run_ticks(1);
        pin("first_ball", 8'd100, 8'd50);

        // Rest of the full frame, then the wrap back to the ball point.
        run_ticks(1);
        pin("lpad_first", 8'd8, 8'd20);
        run_ticks(15);
        pin("lpad_last", 8'd8, 8'd50);
        run_ticks(1);
        pin("rpad_first", 8'd247, 8'd200);
        run_ticks(15);
        pin("rpad_last", 8'd247, 8'd230);
        run_ticks(1);
        pin("frame2_ball", 8'd100, 8'd50);

        // Saturation on the right paddle in the following frame.
        pad_r_y = 8'd240;
        run_ticks(FRAME - 1);
        run_ticks(1 + PAD_PTS + 8);
        pin("rpad_idx7", 8'd247, 8'd254);
        run_ticks(1);
        pin("rpad_idx8_sat", 8'd247, 8'd255);
        run_ticks(7);
        pin("rpad_idx15_sat", 8'd247, 8'd255);

        // Tearing: left base changes after the 3rd point of a frame.
        run_ticks(3);
        pad_l_y = 8'd90;
        run_ticks(1);
        pin("tear_old_base", 8'd8, 8'd24);
        run_ticks(FRAME - 4);
        run_ticks(2);
        pin("tear_new_base", 8'd8, 8'd90);

        // Enable gap after left idx 4, resume at idx 5.
        run_ticks(4);
        pin("gate_idx4", 8'd8, 8'd98);
        enable = 1'b0;
        run_ticks(5);
        pin("gate_hold", 8'd8, 8'd98);
        enable = 1'b1;
        run_ticks(1);
        pin("gate_resume_idx5", 8'd8, 8'd100);

        // Reset after right idx 7 has been emitted.
        run_ticks(PAD_PTS - 6 + 8);
        pin("pre_reset_rpad7", 8'd247, 8'd254);
        do_reset(4);
        run_ticks(1);
        pin("post_reset_ball", 8'd100, 8'd50);

        // Randomized traffic with random enable drops and one reset mid-run.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ball_x  = 8'($urandom_range(0, 255));
                ball_y  = 8'($urandom_range(0, 255));
                pad_l_y = 8'($urandom_range(0, 255));
                pad_r_y = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(200, 255))
                                                      : 8'($urandom_range(0, 255));
            end
            enable = ($urandom_range(0, 5) != 0);
            if (i == 250) do_reset(2);
            tick_period();
        end

        repeat (4) @(negedge sysclk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
